pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/vliw_pkg.sv | 33 +++
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM state encoding,
// the bundle of pipeline-register controls and the canned control patterns.
package vliw_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2
   } pipe_state_t;

   localparam int MEM_TIMEOUT_DEFAULT = 255;
   localparam int CNT_W_DEFAULT       = 16;

   // Control bundle driven to the pipeline registers every cycle.
   typedef struct packed {
      logic pc_en;
      logic ifdc_en;
      logic ifdc_flush;
      logic dcex_en;
      logic dcex_flush;
      logic exmem_en;
      logic memwb_flush;
   } pipe_ctrl_t;

   // Bit order: pc_en, ifdc_en, ifdc_flush, dcex_en, dcex_flush, exmem_en, memwb_flush
   localparam pipe_ctrl_t CTRL_IDLE   = 7'b000_0000; // halted: everything frozen, nothing flushed
   localparam pipe_ctrl_t CTRL_NORMAL = 7'b110_1010; // free-running pipeline
   localparam pipe_ctrl_t CTRL_SQUASH = 7'b111_1110; // taken branch: NOP into IF/DC and DC/EX
   localparam pipe_ctrl_t CTRL_BUBBLE = 7'b000_1110; // load-use: hold front end, one bubble into EX
   localparam pipe_ctrl_t CTRL_FREEZE = 7'b000_0001; // memory stall: hold all, drain NOP into WB
   localparam pipe_ctrl_t CTRL_RESET  = 7'b001_0101; // reset: hold all, every flush asserted

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
   parameter int W = 16
)(
   input  logic         clk,
   input  logic         i_clr_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // Clear has priority; increment only while below the maximum value.
   always_ff @(posedge clk) begin
      if (!i_clr_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: turns hazard, branch, memory and halt requests into
// per-stage enable/flush controls, with a memory-wait watchdog and two
// saturating performance counters.
module pipeline_sequencer
   import vliw_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_stall,
   input  logic             branch_taken,
   input  logic             mem_req_valid,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             ifdc_en,
   output logic             ifdc_flush,
   output logic             dcex_en,
   output logic             dcex_flush,
   output logic             exmem_en,
   output logic             memwb_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] squash_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   pipe_state_t       r_state;
   pipe_state_t       w_state_next;
   logic              r_squash_pending;
   logic              w_squash_pending_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_next;
   logic              r_mem_timeout;
   logic              w_timeout_set;
   logic              w_squash_inc;
   logic              w_stall_inc;
   logic              w_halted;
   pipe_ctrl_t        w_ctrl;

   // Next-state and control decode; outputs depend on state, flags and live inputs.
   always_comb begin
      w_state_next          = r_state;
      w_squash_pending_next = r_squash_pending;
      w_wait_cnt_next       = r_wait_cnt;
      w_timeout_set         = 1'b0;
      w_squash_inc          = 1'b0;
      w_halted              = 1'b0;
      w_ctrl                = CTRL_IDLE;

      if (!rst_n) begin
         w_ctrl = CTRL_RESET;
      end else begin
         case (r_state)
            RUN: begin
               if (mem_req_valid && !mem_ready) begin
                  // Memory stall wins; a branch seen now is replayed when the wait ends.
                  w_ctrl          = CTRL_FREEZE;
                  w_state_next    = MEM_WAIT;
                  w_wait_cnt_next = WAIT_W'(1);
                  if (branch_taken) begin
                     w_squash_pending_next = 1'b1;
                  end
               end else begin
                  if (branch_taken) begin
                     w_ctrl       = CTRL_SQUASH;
                     w_squash_inc = 1'b1;
                  end else if (load_use_stall) begin
                     w_ctrl = CTRL_BUBBLE;
                  end else begin
                     w_ctrl = CTRL_NORMAL;
                  end
                  if (halt_req) begin
                     w_state_next = HALTED;
                  end
               end
            end

            MEM_WAIT: begin
               if (!mem_ready) begin
                  w_ctrl = CTRL_FREEZE;
                  if (branch_taken) begin
                     w_squash_pending_next = 1'b1;
                  end
                  if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                     // Watchdog expired: latch the fault and park the pipeline.
                     w_timeout_set         = 1'b1;
                     w_state_next          = HALTED;
                     w_wait_cnt_next       = '0;
                     w_squash_pending_next = 1'b0;
                  end else begin
                     w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
                  end
               end else begin
                  // Access completes; apply a live or deferred squash exactly once.
                  if (branch_taken || r_squash_pending) begin
                     w_ctrl       = CTRL_SQUASH;
                     w_squash_inc = 1'b1;
                  end else begin
                     w_ctrl = CTRL_NORMAL;
                  end
                  w_squash_pending_next = 1'b0;
                  w_wait_cnt_next       = '0;
                  w_state_next          = halt_req ? HALTED : RUN;
               end
            end

            HALTED: begin
               w_halted = 1'b1;
               if (resume && !r_mem_timeout) begin
                  w_state_next = RUN;
               end
            end

            default: begin
               w_state_next = RUN;
            end
         endcase
      end
   end

   assign w_stall_inc = rst_n && !w_ctrl.pc_en && (r_state != HALTED);

   // State, flags, wait counter and sticky fault; reset discards anything pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= RUN;
         r_squash_pending <= 1'b0;
         r_wait_cnt       <= '0;
         r_mem_timeout    <= 1'b0;
      end else begin
         r_state          <= w_state_next;
         r_squash_pending <= w_squash_pending_next;
         r_wait_cnt       <= w_wait_cnt_next;
         r_mem_timeout    <= r_mem_timeout | w_timeout_set;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .i_clr_n (rst_n),
      .i_inc   (w_stall_inc),
      .o_count (stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_squash_cnt (
      .clk     (clk),
      .i_clr_n (rst_n),
      .i_inc   (w_squash_inc),
      .o_count (squash_count)
   );

   assign pc_en       = w_ctrl.pc_en;
   assign ifdc_en     = w_ctrl.ifdc_en;
   assign ifdc_flush  = w_ctrl.ifdc_flush;
   assign dcex_en     = w_ctrl.dcex_en;
   assign dcex_flush  = w_ctrl.dcex_flush;
   assign exmem_en    = w_ctrl.exmem_en;
   assign memwb_flush = w_ctrl.memwb_flush;
   assign halted      = w_halted;
   assign mem_timeout = r_mem_timeout;

endmodule
